// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the FD -> X -> MW RV32I core: load-use interlock,
// dcache back-pressure stalls, branch redirect/kill, and stall/flush perf counters.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   fd_inst/fd_valid  instruction in FD and its valid flag
//   x_inst/x_valid    instruction in X and its valid flag
//   x_br_taken        control transfer in X resolved taken
//   dmem_req_ready    dcache accepts the X request this cycle
//   dmem_req_valid    X load/store request to dcache
//   stall_fd/stall_x  hold PC+FD / hold X
//   bubble_x/mw       load NOP into X / MW at the next edge
//   kill_fd           squash FD contents
//   pc_redirect       select branch target as next PC
//   cnt_clr           synchronous clear of both perf counters
//   stall_cycles      saturating count of stall_fd cycles
//   flush_cycles      saturating count of kill_fd cycles
module hazard_stall_ctrl #(
    parameter int REDIRECT_LAT = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      fd_inst,
    input  logic             fd_valid,
    input  logic [31:0]      x_inst,
    input  logic             x_valid,
    input  logic             x_br_taken,
    input  logic             dmem_req_ready,
    output logic             dmem_req_valid,
    output logic             stall_fd,
    output logic             stall_x,
    output logic             bubble_x,
    output logic             bubble_mw,
    output logic             kill_fd,
    output logic             pc_redirect,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Redirect counter only ever holds values up to REDIRECT_LAT-1.
    localparam int RCW = (REDIRECT_LAT > 2) ? $clog2(REDIRECT_LAT) : 1;
    localparam logic [RCW-1:0] RCNT_INIT = RCW'(REDIRECT_LAT - 1);
    localparam logic [RCW-1:0] RCNT_ONE  = RCW'(1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_DWAIT    = 2'd1,
        S_REDIRECT = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [RCW-1:0] count_q, count_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // ---------------- decode ----------------
    logic [6:0] fd_op, x_op;
    logic [4:0] fd_rs1, fd_rs2, x_rd;
    logic       fd_use_rs1, fd_use_rs2;
    logic       x_is_load, x_is_mem;
    logic       load_use;

    assign fd_op  = fd_inst[6:0];
    assign fd_rs1 = fd_inst[19:15];
    assign fd_rs2 = fd_inst[24:20];
    assign x_op   = x_inst[6:0];
    assign x_rd   = x_inst[11:7];

    assign fd_use_rs1 = !((fd_op == OP_LUI) || (fd_op == OP_AUIPC) ||
                          (fd_op == OP_JAL));
    assign fd_use_rs2 = (fd_op == OP_BRANCH) || (fd_op == OP_STORE) ||
                        (fd_op == OP_OP);

    assign x_is_load = (x_op == OP_LOAD);
    assign x_is_mem  = x_is_load || (x_op == OP_STORE);

    assign load_use = x_valid && x_is_load && (x_rd != 5'd0) && fd_valid &&
                      ((fd_use_rs1 && (x_rd == fd_rs1)) ||
                       (fd_use_rs2 && (x_rd == fd_rs2)));

    // Opcode/register fields not needed for hazard detection.
    logic unused_bits;
    assign unused_bits = ^{fd_inst[31:25], fd_inst[14:7], x_inst[31:12]};

    // ---------------- next state / controls ----------------
    logic req_c, sfd_c, sx_c, bx_c, bmw_c, kill_c, redir_c;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        req_c   = 1'b0;
        sfd_c   = 1'b0;
        sx_c    = 1'b0;
        bx_c    = 1'b0;
        bmw_c   = 1'b0;
        kill_c  = 1'b0;
        redir_c = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (x_valid && x_br_taken) begin
                    redir_c = 1'b1;
                    kill_c  = 1'b1;
                    if (REDIRECT_LAT > 1) begin
                        state_d = S_REDIRECT;
                        count_d = RCNT_INIT;
                    end
                end else if (x_valid && x_is_mem) begin
                    req_c = 1'b1;
                    if (!dmem_req_ready) begin
                        sfd_c   = 1'b1;
                        sx_c    = 1'b1;
                        bmw_c   = 1'b1;
                        state_d = S_DWAIT;
                    end else if (load_use) begin
                        sfd_c = 1'b1;
                        bx_c  = 1'b1;
                    end
                end else if (load_use) begin
                    sfd_c = 1'b1;
                    bx_c  = 1'b1;
                end
            end
            S_DWAIT: begin
                // The X load/store is held; keep asking until accepted.
                req_c = 1'b1;
                if (!dmem_req_ready) begin
                    sfd_c = 1'b1;
                    sx_c  = 1'b1;
                    bmw_c = 1'b1;
                end else begin
                    state_d = S_RUN;
                    if (load_use) begin
                        sfd_c = 1'b1;
                        bx_c  = 1'b1;
                    end
                end
            end
            S_REDIRECT: begin
                kill_c = 1'b1;
                if (count_q <= RCNT_ONE) begin
                    state_d = S_RUN;
                    count_d = '0;
                end else begin
                    count_d = count_q - RCNT_ONE;
                end
            end
            default: begin
                state_d = S_RUN;
                count_d = '0;
            end
        endcase
    end

    // All controls forced low while reset is asserted.
    assign dmem_req_valid = rst_n & req_c;
    assign stall_fd       = rst_n & sfd_c;
    assign stall_x        = rst_n & sx_c;
    assign bubble_x       = rst_n & bx_c;
    assign bubble_mw      = rst_n & bmw_c;
    assign kill_fd        = rst_n & kill_c;
    assign pc_redirect    = rst_n & redir_c;

    // ---------------- perf counters ----------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (sfd_c && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (kill_c && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            count_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
